// File: rtl/if_id_queue_pkg.sv
// rtl/if_id_queue_pkg.sv - shared widths, NOP encoding and entry layout for the fetch/decode queue
package if_id_queue_pkg;
   localparam int XLEN        = 32;
   localparam int PC_WIDTH    = 32;
   localparam int IFQ_ENTRY_W = 2 * PC_WIDTH + XLEN;

   // addi x0, x0, 0
   localparam logic [XLEN-1:0] NOP_ENC = 32'h0000_0013;

   typedef struct packed {
      logic [PC_WIDTH-1:0] pc;
      logic [PC_WIDTH-1:0] pcplus4;
      logic [XLEN-1:0]     inst;
   } ifq_entry_t;
endpackage

// File: rtl/ifq_storage.sv
// rtl/ifq_storage.sv - DEPTH x IFQ_ENTRY_W register array, one write port, one async read port
module ifq_storage
   import if_id_queue_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic                   clk,
   input  logic                   we,
   input  logic [AW-1:0]          waddr,
   input  logic [IFQ_ENTRY_W-1:0] wdata,
   input  logic [AW-1:0]          raddr,
   output logic [IFQ_ENTRY_W-1:0] rdata
);

   // Contents are deliberately not reset; pointers/count qualify every read.
   logic [IFQ_ENTRY_W-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/if_id_queue.sv
// rtl/if_id_queue.sv - first-word-fall-through instruction queue between fetch and decode
module if_id_queue
   import if_id_queue_pkg::*;
#(
   parameter int               DEPTH    = 4,
   parameter logic [XLEN-1:0]  NOP_INST = NOP_ENC
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       flush,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [PC_WIDTH-1:0]        in_pc,
   input  logic [PC_WIDTH-1:0]        in_pcplus4,
   input  logic [XLEN-1:0]            in_inst,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [PC_WIDTH-1:0]        out_pc,
   output logic [PC_WIDTH-1:0]        out_pcplus4,
   output logic [XLEN-1:0]            out_inst,
   output logic [$clog2(DEPTH):0]     count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [AW-1:0] rptr_q, rptr_d;
   logic [AW-1:0] wptr_q, wptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          push, pop;
   ifq_entry_t    wr_entry, rd_entry;

   // Status comes only from registered count, so in_ready never depends on out_ready.
   assign in_ready  = (count_q != CW'(DEPTH));
   assign out_valid = (count_q != '0);
   assign push      = in_valid && in_ready;
   assign pop       = out_valid && out_ready;
   assign count     = count_q;

   always_comb begin
      rptr_d  = rptr_q;
      wptr_d  = wptr_q;
      count_d = count_q;
      if (flush) begin
         rptr_d  = '0;
         wptr_d  = '0;
         count_d = '0;
      end else begin
         if (push) wptr_d = wptr_q + AW'(1);
         if (pop)  rptr_d = rptr_q + AW'(1);
         if (push && !pop)      count_d = count_q + CW'(1);
         else if (pop && !push) count_d = count_q - CW'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rptr_q  <= '0;
         wptr_q  <= '0;
         count_q <= '0;
      end else begin
         rptr_q  <= rptr_d;
         wptr_q  <= wptr_d;
         count_q <= count_d;
      end
   end

   assign wr_entry = '{pc: in_pc, pcplus4: in_pcplus4, inst: in_inst};

   ifq_storage #(.DEPTH(DEPTH), .AW(AW)) u_storage (
      .clk   (clk),
      .we    (push && !flush),
      .waddr (wptr_q),
      .wdata (wr_entry),
      .raddr (rptr_q),
      .rdata (rd_entry)
   );

   always_comb begin
      out_pc      = '0;
      out_pcplus4 = '0;
      out_inst    = NOP_INST;
      if (out_valid) begin
         out_pc      = rd_entry.pc;
         out_pcplus4 = rd_entry.pcplus4;
         out_inst    = rd_entry.inst;
      end
   end

`ifdef DEBUG
   always_ff @(posedge clk) begin
      if (!rst) begin
         if (flush) $display("if_id_queue: flush discards %0d entries", count_q);
         assert (!(in_valid && !in_ready)) else $error("if_id_queue: push while full");
         assert (!(out_ready && !out_valid)) else $error("if_id_queue: pop while empty");
      end
   end
`endif

endmodule

// File: tb/tb_if_id_queue.sv
// tb/tb_if_id_queue.sv - table-driven directed bench for if_id_queue
module tb_if_id_queue;
   import if_id_queue_pkg::*;

   localparam int DEPTH = 4;
   localparam logic [31:0] NOP = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        flush = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] in_pc = '0;
   logic [31:0] in_pcplus4 = '0;
   logic [31:0] in_inst = '0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] out_pc;
   logic [31:0] out_pcplus4;
   logic [31:0] out_inst;
   logic [2:0]  count;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   if_id_queue #(.DEPTH(DEPTH), .NOP_INST(NOP)) dut (
      .clk(clk), .rst(rst), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_pc(in_pc), .in_pcplus4(in_pcplus4), .in_inst(in_inst),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_pc(out_pc), .out_pcplus4(out_pcplus4), .out_inst(out_inst),
      .count(count)
   );

   typedef struct {
      logic        flush;
      logic        iv;
      logic [31:0] pc;
      logic        ordy;
      int          cnt;
      logic        ov;
      logic        ir;
      logic [31:0] hpc;
   } vec_t;

   vec_t vecs[$];

   function automatic logic [31:0] inst_of(input logic [31:0] pc);
      return 32'h1000_0000 | pc;
   endfunction

   function automatic void add(input logic fl, input logic iv, input logic [31:0] pc,
                               input logic ordy, input int cnt, input logic ov,
                               input logic ir, input logic [31:0] hpc);
      vec_t v;
      v.flush = fl; v.iv = iv; v.pc = pc; v.ordy = ordy;
      v.cnt = cnt; v.ov = ov; v.ir = ir; v.hpc = hpc;
      vecs.push_back(v);
   endfunction

   task automatic chk(input string nm, input int idx, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s vec=%0d got=%h exp=%h", nm, idx, got, exp);
      end
   endtask

   task automatic chk_outputs(input string tag, input int idx, input int cnt, input logic ov,
                              input logic ir, input logic [31:0] hpc);
      chk({tag, "_count"},   idx, 32'(count), 32'(cnt));
      chk({tag, "_valid"},   idx, 32'(out_valid), 32'(ov));
      chk({tag, "_ready"},   idx, 32'(in_ready), 32'(ir));
      chk({tag, "_pc"},      idx, out_pc, ov ? hpc : 32'h0);
      chk({tag, "_pcplus4"}, idx, out_pcplus4, ov ? hpc + 32'd4 : 32'h0);
      chk({tag, "_inst"},    idx, out_inst, ov ? inst_of(hpc) : NOP);
   endtask

   task automatic drive(input logic fl, input logic iv, input logic [31:0] pc, input logic ordy);
      flush = fl; in_valid = iv; in_pc = pc; in_pcplus4 = pc + 32'd4;
      in_inst = inst_of(pc); out_ready = ordy;
   endtask

   initial begin
      // fill three with decode stalled; head must hold
      add(0, 1, 32'h00, 0, 1, 1, 1, 32'h00);
      add(0, 1, 32'h04, 0, 2, 1, 1, 32'h00);
      add(0, 1, 32'h08, 0, 3, 1, 1, 32'h00);
      add(0, 0, 32'h00, 0, 3, 1, 1, 32'h00);
      // reach full, then push while full with a pop: only the pop happens
      add(0, 1, 32'h0C, 0, 4, 1, 0, 32'h00);
      add(0, 1, 32'h10, 1, 3, 1, 1, 32'h04);
      add(0, 1, 32'h10, 1, 3, 1, 1, 32'h08);
      add(0, 0, 32'h00, 1, 2, 1, 1, 32'h0C);
      add(0, 0, 32'h00, 1, 1, 1, 1, 32'h10);
      add(0, 0, 32'h00, 1, 0, 0, 1, 32'h00);
      add(0, 0, 32'h00, 1, 0, 0, 1, 32'h00);
      // streaming 10 entries: pointers wrap, count sits at 1
      add(0, 1, 32'h00, 1, 1, 1, 1, 32'h00);
      for (int i = 1; i < 10; i++) add(0, 1, 32'(4 * i), 1, 1, 1, 1, 32'(4 * i));
      add(0, 0, 32'h00, 1, 0, 0, 1, 32'h00);
      // flush with a push in flight
      add(0, 1, 32'h30, 0, 1, 1, 1, 32'h30);
      add(0, 1, 32'h34, 0, 2, 1, 1, 32'h30);
      add(0, 1, 32'h38, 0, 3, 1, 1, 32'h30);
      add(1, 1, 32'h40, 1, 0, 0, 1, 32'h00);
      add(0, 1, 32'h80, 0, 1, 1, 1, 32'h80);
      add(0, 0, 32'h00, 1, 0, 0, 1, 32'h00);

      // reset state
      drive(0, 0, 32'h0, 0);
      #12;
      chk_outputs("reset", -1, 0, 1'b0, 1'b1, 32'h0);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk); #1;
      chk_outputs("idle", -1, 0, 1'b0, 1'b1, 32'h0);

      foreach (vecs[i]) begin
         @(negedge clk);
         drive(vecs[i].flush, vecs[i].iv, vecs[i].pc, vecs[i].ordy);
         @(posedge clk); #1;
         chk_outputs("vec", i, vecs[i].cnt, vecs[i].ov, vecs[i].ir, vecs[i].hpc);
      end

      // async reset between edges mid-burst
      @(negedge clk);
      drive(0, 1, 32'h200, 0);
      @(posedge clk); #1;
      drive(0, 1, 32'h204, 0);
      @(posedge clk); #1;
      chk_outputs("preburst", -2, 2, 1'b1, 1'b1, 32'h200);
      #2;
      rst = 1'b1;
      #1;
      chk_outputs("asyncrst", -2, 0, 1'b0, 1'b1, 32'h0);
      @(negedge clk);
      drive(0, 0, 32'h0, 0);
      rst = 1'b0;
      @(negedge clk);
      drive(0, 1, 32'h100, 0);
      @(posedge clk); #1;
      chk_outputs("postrst", -2, 1, 1'b1, 1'b1, 32'h100);
      @(negedge clk);
      drive(0, 0, 32'h0, 1);
      @(posedge clk); #1;
      chk_outputs("drain", -2, 0, 1'b0, 1'b1, 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/if_id_queue.md
Name: if_id_queue

Overview:
- Decoupling instruction queue directly downstream of the fetch stage and upstream of decode.
- Captures each fetched instruction with its pc and pc+4 and buffers up to DEPTH entries.
- Presents entries to decode in order, first-word-fall-through, with valid/ready handshakes on both sides.
- Flushes all entries on a control-flow redirect so that wrong-path instructions never reach decode.

Parameters:
- DEPTH, 4, number of entries; power of two, minimum 2.
- NOP_INST, 32'h00000013, value driven on out_inst when the queue is empty (addi x0,x0,0).

Ports:
- clk  input  1  clock
- rst  input  1  reset; asynchronous, active-high
- flush  input  1  redirect (pcsrc taken); discards all entries
- in_valid  input  1  fetch stage offers an entry
- in_ready  output  1  queue can accept an entry
- in_pc  input  `PC_WIDTH  pc of the offered instruction
- in_pcplus4  input  `PC_WIDTH  pc+4 of the offered instruction
- in_inst  input  `XLEN  offered instruction word
- out_valid  output  1  head entry is valid
- out_ready  input  1  decode consumes the head this cycle
- out_pc  output  `PC_WIDTH  head pc
- out_pcplus4  output  `PC_WIDTH  head pc+4
- out_inst  output  `XLEN  head instruction, or NOP_INST when empty
- count  output  $clog2(DEPTH)+1  number of valid entries

Behaviour:
- Reset (asynchronous, immediate):
  - Read pointer, write pointer and count go to 0.
  - out_valid=0, in_ready=1, out_pc=0, out_pcplus4=0, out_inst=NOP_INST.
  - Entry storage is not reset.
- Reset asserted mid-operation drops all entries; no entry survives.
- Storage is a circular buffer of DEPTH entries, each {pc, pcplus4, inst}.
  - Pointers are $clog2(DEPTH) bits wide and wrap naturally from DEPTH-1 to 0.
- Status signals:
  - in_ready = (count != DEPTH); purely from registered state, no combinational path from out_ready.
  - out_valid = (count != 0).
- Push: in_valid && in_ready at a rising edge writes the entry at wptr, then wptr+1 and count+1.
- Pop: out_valid && out_ready at a rising edge advances rptr+1 and decrements count.
- Simultaneous push and pop (not full, not empty): both happen; count unchanged.
- Full: push is refused even if a pop occurs in the same cycle. The entry is accepted in the next cycle.
- Empty: a pop attempt is ignored.
  - Latency is 1 cycle: an entry pushed at edge N is visible at the outputs after edge N.
  - There is no in→out bypass.
- Head outputs are read combinationally from storage[rptr], first-word-fall-through, while out_valid=1.
  - When out_valid=0: out_pc=0, out_pcplus4=0, out_inst=NOP_INST.
- Flush (synchronous, highest priority):
  - Pointers and count go to 0.
  - A push or pop in the same cycle is ignored; the in-flight push is discarded.
  - in_ready stays 1 during the flush cycle.
- Outputs are stable between edges for a fixed head; head values do not change while out_valid && !out_ready.
- Ordering: strict FIFO; pc order at the output equals accept order.
- DEBUG build:
  - $display on flush, showing the discarded count.
  - Assertion fires if a push is attempted while full, or a pop while empty.

Decomposition:
- Existing shared define file (riscv_def.v) supplies XLEN and PC_WIDTH.
- Add to the same file:
  - NOP encoding constant, used for NOP_INST.
  - IFQ_ENTRY_W = 2*PC_WIDTH + XLEN.
- One natural sub-module: ifq_storage, a DEPTH x IFQ_ENTRY_W register array with one write port and one asynchronous read port.
  - Pointer, count and handshake logic stay in if_id_queue.

Test Plan:
- Reset then idle → out_valid=0, in_ready=1, count=0, out_inst=32'h00000013.
- Push pc=0x0,0x4,0x8 with out_ready=0 → count=3; out_pc=0x0, out_inst=first word held stable across cycles.
- Fill DEPTH=4 (pc 0x0..0xC), then hold in_valid=1 with pc 0x10 and out_ready=1 → first cycle only pops (count 3), next cycle accepts 0x10; output sequence is 0x0,0x4,0x8,0xC,0x10.
- Continuous push and pop for 10 entries (pc 0x0..0x24) → pointers wrap and outputs appear in exact order with 1-cycle latency; count stays at 1 in steady state.
- With 3 entries queued, assert flush together with in_valid (pc 0x40) → next cycle count=0 and out_valid=0; 0x40 is discarded; the following push of 0x80 emerges as the head.
- Assert rst asynchronously mid-burst, between clock edges → outputs clear immediately to their reset values; after release the first push, 0x100, is the head.
